adc_responder: RTL and testbench

Synthesizable emulator of the external 8-bit multiplexed parallel ADC, i.e. the responder side of the convst/eoc/cs/rd handshake that the sampler initiates. It lets the full sampler -> ping-pong -> xcorr -> argmax chain run on the FPGA with no ADC board. It can also serve as a bench model. Each channel returns a deterministic ramp with a known per-channel lag, so the xcorr peak index is predictable.

---
 rtl/adc_if_pkg.sv | 20 ++
 rtl/adc_pattern_gen.sv | 53 +++++
 rtl/adc_responder.sv | 124 ++++++++++++
 tb/tb_adc_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/adc_if_pkg.sv
// Shared widths and the responder state type for the multiplexed parallel ADC interface.
// The sampler imports the same package so both sides of the handshake agree on widths.
package adc_if_pkg;

  localparam int ADC_W = 8;
  localparam int CH_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    READY,
    READ
  } adc_state_e;

  // k*step truncated to the sample width; used as a per-channel constant lag.
  function automatic logic [ADC_W-1:0] lag_offset(input int k, input int step);
    return ADC_W'(k * step);
  endfunction

endpackage

// File: rtl/adc_pattern_gen.sv
// Per-channel frame counters and the test-pattern sample for the selected channel.
// The sample is combinational from the current counter; the counter advances on i_adv.
module adc_pattern_gen
  import adc_if_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int LAG_STEP = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH_W-1:0]  i_ch,
  input  logic             i_pattern_sel,
  input  logic             i_adv,
  input  logic [CH_W-1:0]  i_adv_ch,
  output logic [ADC_W-1:0] o_sample
);

  localparam int N_SLOTS = 1 << CH_W;

  logic [ADC_W-1:0] r_frame_cnt [N_SLOTS];
  logic [ADC_W-1:0] w_ramp;
  logic             w_valid;

  // NOTE: the counter array is reset on purpose: the emitted ramp must be
  // deterministic from reset, so this storage cannot be left uninitialised.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_SLOTS; k++) r_frame_cnt[k] <= '0;
    end else if (i_adv) begin
      for (int k = 0; k < N_SLOTS; k++) begin
        if (k < NUM_CH && i_adv_ch == CH_W'(k))
          r_frame_cnt[k] <= r_frame_cnt[k] + 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_ramp  = '0;
    w_valid = 1'b0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (i_ch == CH_W'(k)) begin
        w_ramp  = r_frame_cnt[k] - lag_offset(k, LAG_STEP);
        w_valid = (k < NUM_CH);
      end
    end
  end

  assign o_sample = !w_valid      ? '0 :
                    i_pattern_sel ? {i_ch, {(ADC_W-CH_W){1'b0}}} :
                                    w_ramp;

endmodule

// File: rtl/adc_responder.sv
// Responder side of the convst/eoc/cs/rd ADC handshake, producing deterministic
// per-channel ramps so the downstream correlation peak is predictable without an ADC board.
module adc_responder
  import adc_if_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CONV_CYCLES = 16,
  parameter int LAG_STEP    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH_W-1:0]  chnl,
  input  logic             n_convst,
  input  logic             n_cs,
  input  logic             n_rd,
  input  logic             pattern_sel,
  output logic             n_eoc,
  output logic [ADC_W-1:0] adc_out,
  output logic             adc_oe,
  output logic             overrun,
  output logic             early_rd
);

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  adc_state_e       r_state;
  logic             r_convst_q;
  logic [CH_W-1:0]  r_ch;
  logic [ADC_W-1:0] r_sample;
  logic [CNT_W-1:0] r_cnt;
  logic             r_eoc_n;
  logic [ADC_W-1:0] r_adc_out;
  logic             r_adc_oe;
  logic             r_overrun;
  logic             r_early_rd;

  logic             w_start;
  logic             w_read;
  logic             w_adv;
  logic [ADC_W-1:0] w_sample;

  assign w_start = r_convst_q & ~n_convst;
  assign w_read  = ~n_cs & ~n_rd;
  assign w_adv   = (r_state == READY) && w_read;

  adc_pattern_gen #(
    .NUM_CH   (NUM_CH),
    .LAG_STEP (LAG_STEP)
  ) u_pattern_gen (
    .clk           (clk),
    .rst           (rst),
    .i_ch          (chnl),
    .i_pattern_sel (pattern_sel),
    .i_adv         (w_adv),
    .i_adv_ch      (r_ch),
    .o_sample      (w_sample)
  );

  // NOTE: all state uses non-blocking assignments so every register sees
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      // Treat strobe as already low so a strobe held low through reset is not a start.
      r_convst_q <= 1'b0;
      r_ch       <= '0;
      r_sample   <= '0;
      r_cnt      <= '0;
      r_eoc_n    <= 1'b1;
      r_adc_out  <= '0;
      r_adc_oe   <= 1'b0;
      r_overrun  <= 1'b0;
      r_early_rd <= 1'b0;
    end else begin
      r_convst_q <= n_convst;
      if (w_start && r_state != IDLE) r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          r_adc_oe <= w_read;
          if (w_read) r_early_rd <= 1'b1;
          if (w_start) begin
            r_ch     <= chnl;
            r_sample <= w_sample;
            r_cnt    <= CNT_W'(CONV_CYCLES - 1);
            r_state  <= CONVERT;
          end
        end
        CONVERT: begin
          r_adc_oe <= w_read;
          if (w_read) r_early_rd <= 1'b1;
          if (r_cnt == '0) begin
            r_eoc_n <= 1'b0;
            r_state <= READY;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        READY: begin
          if (w_read) begin
            r_adc_out <= r_sample;
            r_adc_oe  <= 1'b1;
            r_eoc_n   <= 1'b1;
            r_state   <= READ;
          end
        end
        READ: begin
          if (n_rd || n_cs) begin
            r_adc_oe <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign n_eoc    = r_eoc_n;
  assign adc_out  = r_adc_out;
  assign adc_oe   = r_adc_oe;
  assign overrun  = r_overrun;
  assign early_rd = r_early_rd;

endmodule

// File: tb/tb_adc_responder.sv
// Scoreboard bench for adc_responder: expected samples are queued at each start
// from a reference frame-counter model and compared when the read returns data.
module tb_adc_responder;

  localparam int NUM_CH      = 8;
  localparam int CONV_CYCLES = 16;
  localparam int LAG_STEP    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] chnl;
  logic       n_convst;
  logic       n_cs;
  logic       n_rd;
  logic       pattern_sel;
  logic       n_eoc;
  logic [7:0] adc_out;
  logic       adc_oe;
  logic       overrun;
  logic       early_rd;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_frame [NUM_CH];
  logic [7:0] m_last;
  logic [7:0] sb_q [$];

  always #5 clk = ~clk;

  adc_responder #(
    .NUM_CH      (NUM_CH),
    .CONV_CYCLES (CONV_CYCLES),
    .LAG_STEP    (LAG_STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .chnl        (chnl),
    .n_convst    (n_convst),
    .n_cs        (n_cs),
    .n_rd        (n_rd),
    .pattern_sel (pattern_sel),
    .n_eoc       (n_eoc),
    .adc_out     (adc_out),
    .adc_oe      (adc_oe),
    .overrun     (overrun),
    .early_rd    (early_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) m_frame[k] = 8'h00;
    m_last = 8'h00;
    sb_q.delete();
  endtask

  // One full conversion; ov_at / er_at (edges after the start edge, 0 = off)
  // inject a second start or an early read while converting.
  task automatic do_conv(input logic [2:0] ch, input logic pat, input int ov_at, input int er_at);
    logic [7:0] exp;
    logic [7:0] got_exp;
    int         e;
    bit         found;
    exp = pat ? {ch, 5'b0} : m_frame[ch] - 8'(int'(ch) * LAG_STEP);
    sb_q.push_back(exp);
    chnl        = ch;
    pattern_sel = pat;
    n_convst    = 1'b0;
    tick();
    n_convst    = 1'b1;
    chnl        = ~ch;
    pattern_sel = ~pat;
    e     = 0;
    found = 1'b0;
    while (!found && e < 64) begin
      e++;
      tick();
      if (!n_eoc) begin
        found = 1'b1;
      end else begin
        if (e == ov_at) n_convst = 1'b0;
        if (ov_at != 0 && e == ov_at + 1) begin
          n_convst = 1'b1;
          check("overrun_set", overrun, 1);
        end
        if (e == er_at) begin
          n_cs = 1'b0;
          n_rd = 1'b0;
        end
        if (er_at != 0 && e == er_at + 1) begin
          check("early_oe", adc_oe, 1);
          check("early_data", adc_out, m_last);
          check("early_flag", early_rd, 1);
          n_cs = 1'b1;
          n_rd = 1'b1;
        end
        if (er_at != 0 && e == er_at + 2) check("early_oe_drop", adc_oe, 0);
      end
    end
    check("eoc_latency", e, CONV_CYCLES);
    n_cs = 1'b0;
    n_rd = 1'b0;
    tick();
    got_exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
    check("rd_data", adc_out, got_exp);
    check("rd_oe", adc_oe, 1);
    check("rd_eoc_high", n_eoc, 1);
    m_last = got_exp;
    m_frame[ch] = m_frame[ch] + 8'd1;
    n_cs = 1'b1;
    n_rd = 1'b1;
    tick();
    check("release_oe", adc_oe, 0);
    check("release_hold", adc_out, m_last);
  endtask

  initial begin
    int lows;
    rst         = 1'b1;
    chnl        = 3'd0;
    n_convst    = 1'b1;
    n_cs        = 1'b1;
    n_rd        = 1'b1;
    pattern_sel = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_eoc", n_eoc, 1);
    check("rst_out", adc_out, 8'h00);
    check("rst_oe", adc_oe, 0);
    check("rst_overrun", overrun, 0);
    check("rst_early", early_rd, 0);
    rst = 1'b0;
    tick();

    // Lagged ramp: ch0 reads 0..4, then ch2 reads 0-6.
    for (int i = 0; i < 5; i++) do_conv(3'd0, 1'b0, 0, 0);
    do_conv(3'd2, 1'b0, 0, 0);
    check("ch2_lag", adc_out, 8'hFA);

    do_conv(3'd5, 1'b1, 0, 0);
    check("pattern_ch5", adc_out, 8'hA0);

    // Overrun mid-conversion; follow-up read proves a single frame advance.
    do_conv(3'd3, 1'b0, 5, 0);
    check("overrun_sticky", overrun, 1);
    do_conv(3'd3, 1'b0, 0, 0);
    check("ch3_single_adv", adc_out, 8'hF8);

    do_conv(3'd4, 1'b0, 0, 3);
    check("early_sticky", early_rd, 1);

    // 257 conversions on ch1 cover the 255 -> 0 frame counter wrap.
    for (int i = 0; i < 257; i++) do_conv(3'd1, 1'b0, 0, 0);
    check("wrap_last", adc_out, 8'hFD);

    // Reset in the middle of a conversion aborts it.
    chnl     = 3'd0;
    n_convst = 1'b0;
    tick();
    n_convst = 1'b1;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!n_eoc) lows++;
    end
    check("abort_no_eoc", lows, 0);
    check("abort_overrun_clr", overrun, 0);
    check("abort_early_clr", early_rd, 0);
    check("abort_out_clr", adc_out, 8'h00);
    do_conv(3'd0, 1'b0, 0, 0);
    check("post_rst_ch0", adc_out, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
